column_readout_ctrl: RTL and testbench

- Column-end read controller at the bottom of a pixel column's switch-cell chain.
- On each event-ready strobe, it samples the column's pending-hit count and pops that many 46-bit hit words out of the chain via a read strobe.
- It frames the words with a header and a trailer and buffers them in a small FIFO for the global readout stage, using a valid/ready handshake.

---
 rtl/column_readout_ctrl.sv | 165 ++++++++++++++++
 tb/tb_column_readout_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/column_readout_ctrl.sv
// Column-end readout controller: pops pending hit words from a pixel
// column's switch-cell chain, frames them with a header and a trailer,
// and buffers the framed words in a small FIFO for the global readout.
module column_readout_ctrl #(
  parameter int DATAWIDTH = 46,
  parameter int FIFODEPTH = 8,
  parameter int MAXHITS   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [4:0]           upHits,
  input  logic [DATAWIDTH-1:0] upData,
  output logic                 upRead,
  output logic [DATAWIDTH+1:0] outData,
  output logic                 outValid,
  input  logic                 outReady,
  output logic                 busy,
  output logic [11:0]          eventCount
);

  localparam int AW = $clog2(FIFODEPTH);
  localparam int PW = AW + 1;
  localparam logic [4:0] MAXHITS5 = 5'(MAXHITS);
  localparam logic [1:0] TYPEHEADER  = 2'b01;
  localparam logic [1:0] TYPEHIT     = 2'b10;
  localparam logic [1:0] TYPETRAILER = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEADER  = 2'd1,
    READ    = 2'd2,
    TRAILER = 2'd3
  } stateT;

  stateT state, nextState;

  logic [4:0] nHits;
  logic [4:0] remaining;
  logic [4:0] nRead;
  logic       trunc;
  logic       missed;
  logic       inflight;

  logic [DATAWIDTH+1:0] mem [FIFODEPTH];
  logic [PW-1:0]        wrPtr;
  logic [PW-1:0]        rdPtr;
  logic [PW-1:0]        occupancy;
  logic [PW:0]          committed;
  logic                 hasRoom;
  logic                 fifoEmpty;
  logic                 fifoFull;
  logic                 pushEn;
  logic [DATAWIDTH+1:0] pushWord;
  logic                 popEn;
  logic                 accept;
  logic [4:0]           clampedHits;

  // A read already issued to the chain holds a slot, so it counts against room.
  assign occupancy = wrPtr - rdPtr;
  assign committed = {1'b0, occupancy} + {{PW{1'b0}}, inflight};
  assign hasRoom   = committed < (PW+1)'(FIFODEPTH);

  // Equal pointers mean empty; differing only in the MSB means full.
  assign fifoEmpty = (wrPtr == rdPtr);
  assign fifoFull  = (wrPtr[PW-1] != rdPtr[PW-1]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);

  assign outValid    = !fifoEmpty;
  assign popEn       = outValid && outReady;
  assign outData     = outValid ? mem[rdPtr[AW-1:0]] : '0;
  assign busy        = (state != IDLE);
  assign accept      = (state == IDLE) && start;
  assign clampedHits = (upHits > MAXHITS5) ? MAXHITS5 : upHits;

  // Next-state, chain read strobe and FIFO push selection.
  always_comb begin
    nextState = state;
    upRead    = 1'b0;
    pushEn    = 1'b0;
    pushWord  = '0;
    if (inflight) begin
      pushEn   = 1'b1;
      pushWord = {TYPEHIT, upData};
    end
    case (state)
      IDLE: begin
        if (start) nextState = HEADER;
      end
      HEADER: begin
        if (hasRoom) begin
          pushEn    = 1'b1;
          pushWord  = {TYPEHEADER, DATAWIDTH'({eventCount, nHits})};
          nextState = (nHits != 5'd0) ? READ : TRAILER;
        end
      end
      READ: begin
        if (remaining != 5'd0) begin
          upRead = hasRoom;
        end else begin
          nextState = TRAILER;
        end
      end
      TRAILER: begin
        if (hasRoom) begin
          pushEn    = 1'b1;
          pushWord  = {TYPETRAILER, DATAWIDTH'({missed, trunc, nRead, 1'b0})};
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nextState;
  end

  // Event bookkeeping: counters, hit budget and sticky trailer flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      nHits      <= '0;
      remaining  <= '0;
      nRead      <= '0;
      trunc      <= 1'b0;
      missed     <= 1'b0;
      inflight   <= 1'b0;
      eventCount <= '0;
    end else begin
      inflight <= upRead;
      if (accept) begin
        nHits      <= clampedHits;
        remaining  <= clampedHits;
        nRead      <= '0;
        trunc      <= (upHits > MAXHITS5);
        eventCount <= eventCount + 12'd1;
      end
      if (upRead) remaining <= remaining - 5'd1;
      if (inflight) nRead <= nRead + 5'd1;
      if (start && (state != IDLE)) missed <= 1'b1;
      if ((state == TRAILER) && hasRoom) begin
        missed <= 1'b0;
        trunc  <= 1'b0;
      end
    end
  end

  // FIFO pointers; push and pop may both happen in one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (pushEn && !fifoFull) wrPtr <= wrPtr + PW'(1);
      if (popEn)               rdPtr <= rdPtr + PW'(1);
    end
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (pushEn && !fifoFull) mem[wrPtr[AW-1:0]] <= pushWord;
  end

endmodule

// File: tb/tb_column_readout_ctrl.sv
// Scoreboard bench for column_readout_ctrl: directed events push their
// expected framed words into a queue, an independent monitor pops and
// compares each word the DUT hands downstream.
module tb_column_readout_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic [4:0]  upHits;
  logic [45:0] upData;
  logic        upRead;
  logic [47:0] outData;
  logic        outValid;
  logic        outReady;
  logic        busy;
  logic [11:0] eventCount;

  int          errors;
  int          checks;
  int          readCount;
  bit          pendWord;
  int          wordIdx;
  logic [45:0] wordBase;
  logic [47:0] expQ[$];

  column_readout_ctrl #(.DATAWIDTH(46), .FIFODEPTH(8), .MAXHITS(16)) dut (
    .clk(clk), .reset(reset), .start(start), .upHits(upHits),
    .upData(upData), .upRead(upRead), .outData(outData),
    .outValid(outValid), .outReady(outReady), .busy(busy),
    .eventCount(eventCount)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [47:0] hdr(input int ev, input int n);
    return {2'b01, 29'b0, 12'(ev), 5'(n)};
  endfunction

  function automatic logic [47:0] trl(input bit m, input bit t, input int n);
    return {2'b11, 38'b0, m, t, 5'(n), 1'b0};
  endfunction

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkOutput();
    logic [47:0] exp;
    if (expQ.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL unexpectedWord: got %h expected none", outData);
    end else begin
      exp = expQ.pop_front();
      check("outData", outData, exp);
    end
  endtask

  // Monitor: compare every word accepted downstream, count chain reads.
  always @(negedge clk) begin
    if (reset && outValid && outReady) checkOutput();
    if (reset && upRead) begin
      readCount++;
      pendWord = 1'b1;
    end
  end

  // Chain model: a word appears on upData the cycle after each read strobe.
  always @(posedge clk) begin
    #1;
    if (pendWord) begin
      upData   = wordBase + 46'(wordIdx);
      wordIdx++;
      pendWord = 1'b0;
    end
  end

  // Queue the expected frame, then pulse start for one cycle.
  task automatic applyStimulus(input int hits, input int ev, input int base, input bit expMissed);
    int n;
    n = (hits > 16) ? 16 : hits;
    wordBase = 46'(base);
    wordIdx  = 0;
    expQ.push_back(hdr(ev, n));
    for (int i = 0; i < n; i++) expQ.push_back({2'b10, 46'(base + i)});
    expQ.push_back(trl(expMissed, hits > 16, n));
    start  = 1'b1;
    upHits = 5'(hits);
    @(posedge clk);
    #1;
    start  = 1'b0;
  endtask

  task automatic waitIdle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(posedge clk);
      #1;
      if (!busy && !outValid && expQ.size() == 0) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL waitIdle: got timeout expected idle (queue=%0d)", expQ.size());
    end
  endtask

  initial begin
    int cyc;
    errors   = 0;
    checks   = 0;
    readCount = 0;
    pendWord = 1'b0;
    wordIdx  = 0;
    wordBase = '0;
    reset    = 1'b0;
    start    = 1'b0;
    upHits   = '0;
    upData   = '0;
    outReady = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("resetBusy", 48'(busy), 48'd0);
    check("resetValid", 48'(outValid), 48'd0);
    check("resetCount", 48'(eventCount), 48'd0);
    check("resetRead", 48'(upRead), 48'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] basic event, 3 hits");
    readCount = 0;
    applyStimulus(3, 1, 'h1000, 1'b0);
    cyc = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (busy) cyc++;
      else break;
    end
    check("busyCycles", 48'(cyc), 48'd6);
    waitIdle();
    check("reads3", 48'(readCount), 48'd3);
    check("count1", 48'(eventCount), 48'd1);

    $display("[TB] empty event");
    readCount = 0;
    applyStimulus(0, 2, 'h1800, 1'b0);
    waitIdle();
    check("reads0", 48'(readCount), 48'd0);

    $display("[TB] truncated event, 20 hits");
    readCount = 0;
    applyStimulus(20, 3, 'h2000, 1'b0);
    waitIdle();
    check("reads16", 48'(readCount), 48'd16);

    $display("[TB] backpressure, 10 hits");
    readCount = 0;
    outReady  = 1'b0;
    applyStimulus(10, 4, 'h3000, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    check("stallReads", 48'(readCount), 48'd7);
    check("stallValid", 48'(outValid), 48'd1);
    outReady = 1'b1;
    waitIdle();
    check("reads10", 48'(readCount), 48'd10);

    $display("[TB] start while busy");
    applyStimulus(4, 5, 'h4000, 1'b1);
    @(posedge clk);
    #1;
    start  = 1'b1;
    upHits = 5'd7;
    @(posedge clk);
    #1;
    start  = 1'b0;
    waitIdle();
    check("countMissed", 48'(eventCount), 48'd5);
    applyStimulus(1, 6, 'h4800, 1'b0);
    waitIdle();

    $display("[TB] event counter wrap");
    for (int ev = 7; ev <= 4095; ev++) begin
      applyStimulus(0, ev, 'h0, 1'b0);
      waitIdle();
    end
    check("count4095", 48'(eventCount), 48'd4095);
    applyStimulus(0, 0, 'h0, 1'b0);
    waitIdle();
    check("countWrap", 48'(eventCount), 48'd0);

    $display("[TB] reset mid-read");
    applyStimulus(10, 1, 'h6000, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("midRead", 48'(upRead), 48'd0);
    check("midValid", 48'(outValid), 48'd0);
    check("midBusy", 48'(busy), 48'd0);
    check("midCount", 48'(eventCount), 48'd0);
    check("midData", outData, 48'd0);
    expQ.delete();
    @(posedge clk);
    #1;
    pendWord = 1'b0;
    reset    = 1'b1;
    @(posedge clk);
    #1;
    pendWord = 1'b0;
    applyStimulus(2, 1, 'h5000, 1'b0);
    waitIdle();
    check("countAfterReset", 48'(eventCount), 48'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
